pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised elastic pipeline register. Replaces the fixed-field, always-advancing stage registers
//  (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
//  Adds a ready/valid handshake, a 2-entry skid buffer so stalls do not drop instructions,
//  synchronous flush to a zeroed bubble, and saturating stall/flush counters for performance debug.
// PARAMETERS
//  CTRL_W          8    control field width; ID/EX packs {WB[1:0], M[2:0], EX[2:0]}
//  DATA_W          275  data field width; ID/EX packs {pc, rd1, rd2, imm, rs1, rs2, rd, funct}
//  ZERO_ON_BUBBLE  1    1: out_data forced to 0 while out_valid=0; 0: out_data holds its last value
//  CNT_W           16   width of the stall and flush counters
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high
//  flush      in   1       synchronous kill of all held entries (branch taken / hazard bubble)
//  in_valid   in   1       upstream stage presents an instruction
//  in_ready   out  1       this stage accepts; registered, equals !skid_valid
//  in_ctrl    in   CTRL_W  upstream control bits
//  in_data    in   DATA_W  upstream data bits
//  out_valid  out  1       main entry valid
//  out_ready  in   1       downstream stage accepts
//  out_ctrl   out  CTRL_W  main entry control; always 0 while out_valid=0
//  out_data   out  DATA_W  main entry data; see ZERO_ON_BUBBLE
//  stall_cnt  out  CNT_W   cycles with out_valid & !out_ready; saturates at all-ones
//  flush_cnt  out  CNT_W   flushes that discarded at least one valid entry; saturates
// BEHAVIOUR
//  - Handshake signals: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Reset: state=EMPTY; in_ready=1; out_valid=0; out_ctrl, out_data, skid regs, counters = 0.
//  - Latency and throughput: 1 cycle in->out from EMPTY; 1 transfer/cycle while out_ready=1.
//  - FSM states: EMPTY (no entries), ONE (main valid), FULL (main + skid valid).
//  - EMPTY: in_fire -> ONE, main<=in.
//  - ONE, both fire: stay ONE, main<=in.
//  - ONE, in_fire & !out_ready: -> FULL, skid<=in, in_ready drops next cycle.
//  - ONE, out_fire only: -> EMPTY.
//  - ONE, neither fires: hold.
//  - FULL: in_ready=0. out_fire -> ONE, main<=skid, skid cleared, in_ready=1 next cycle.
//  - FULL, no out_fire: hold; entries are never overwritten or dropped.
//  - Order is strictly FIFO; skid never bypasses main.
//  - flush=1: next state EMPTY, out_valid=0, out_ctrl=0, skid cleared, in_ready=1.
//    A same-cycle in_fire is discarded.
//    Flush overrides every transition; a same-cycle out_fire still counts as delivered downstream.
//  - flush_cnt increments when flush=1 and (main valid | skid valid); a flush on EMPTY is not counted.
//  - stall_cnt increments on out_valid & !out_ready, including the flush cycle.
//  - reset and flush together: reset wins; counters cleared.
//  - Both counters hold at 2^CNT_W-1, with no wrap.
//  - Bubble: out_ctrl is zero whenever out_valid=0, so a stage that ignores valid still sees a nop.
//  - in_ctrl and in_data are sampled only on in_fire; X on them while in_valid=0 must not propagate.
// STRUCTURE
//  - pipe_pkg holds FSM localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
//  - pipe_pkg also holds the per-stage widths (ID_EX_CTRL_W=8, ID_EX_DATA_W=275, ...)
//    and the field offsets for pack/unpack.
//  - Sub-module pipe_sat_cnt #(CNT_W) (clk, reset, clr, inc, q) is instanced twice, for stall and flush.
//  - Main and skid registers and the FSM stay in this module; no other hierarchy.
// TESTING
//  1 Stream: in_valid=1, out_ready=1, ctrl 0x01..0x0A on 10 cycles
//    -> same sequence out 1 cycle later; in_ready never 0; stall_cnt=0.
//  2 Backpressure: send A,B with out_ready=0 from cycle 1
//    -> state FULL, in_ready=0, C held upstream.
//    Release out_ready -> A,B,C out in order; stall_cnt equals the stalled cycles.
//  3 Flush in FULL: A in main, B in skid, flush=1 with in_valid=1 (C)
//    -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C lost; flush_cnt=1.
//  4 Flush on EMPTY -> flush_cnt stays 0. ZERO_ON_BUBBLE=1 -> out_data=0 after flush.
//    ZERO_ON_BUBBLE=0 -> out_data keeps its last value.
//  5 Saturation: CNT_W=4, hold out_valid=1 & out_ready=0 for 20 cycles
//    -> stall_cnt reaches 15 and stays 15.
//  6 Reset mid-FULL with flush=1 in the same cycle
//    -> all outputs at reset values next cycle; counters 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: FSM encoding, per-stage field widths and ID/EX pack offsets.
// No logic of its own; latency and backpressure are defined by pipe_stage_buf.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int XLEN    = 64;
    localparam int REG_W   = 5;
    localparam int FUNCT_W = 4;

    localparam int IF_ID_DATA_W  = XLEN + 32;
    localparam int ID_EX_CTRL_W  = 8;
    localparam int ID_EX_DATA_W  = 4 * XLEN + 3 * REG_W + FUNCT_W;
    localparam int EX_MEM_CTRL_W = 5;
    localparam int EX_MEM_DATA_W = 3 * XLEN + 1 + REG_W;
    localparam int MEM_WB_CTRL_W = 2;
    localparam int MEM_WB_DATA_W = 2 * XLEN + REG_W;

    // ID/EX control: {WB[1:0], M[2:0], EX[2:0]}
    localparam int ID_EX_EX_LSB = 0;
    localparam int ID_EX_M_LSB  = 3;
    localparam int ID_EX_WB_LSB = 6;

    // ID/EX data: {pc, rd1, rd2, imm, rs1, rs2, rd, funct}, funct at bit 0
    localparam int ID_EX_FUNCT_LSB = 0;
    localparam int ID_EX_RD_LSB    = ID_EX_FUNCT_LSB + FUNCT_W;
    localparam int ID_EX_RS2_LSB   = ID_EX_RD_LSB + REG_W;
    localparam int ID_EX_RS1_LSB   = ID_EX_RS2_LSB + REG_W;
    localparam int ID_EX_IMM_LSB   = ID_EX_RS1_LSB + REG_W;
    localparam int ID_EX_RD2_LSB   = ID_EX_IMM_LSB + XLEN;
    localparam int ID_EX_RD1_LSB   = ID_EX_RD2_LSB + XLEN;
    localparam int ID_EX_PC_LSB    = ID_EX_RD1_LSB + XLEN;

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] m;
        logic [2:0] ex;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rd1;
        logic [XLEN-1:0]    rd2;
        logic [XLEN-1:0]    imm;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
        logic [FUNCT_W-1:0] funct;
    } id_ex_data_t;

    function automatic logic [ID_EX_DATA_W-1:0] pack_id_ex_data(input id_ex_data_t f);
        return f;
    endfunction

    function automatic id_ex_data_t unpack_id_ex_data(input logic [ID_EX_DATA_W-1:0] v);
        return id_ex_data_t'(v);
    endfunction

    function automatic logic [ID_EX_CTRL_W-1:0] pack_id_ex_ctrl(input id_ex_ctrl_t f);
        return f;
    endfunction

    function automatic id_ex_ctrl_t unpack_id_ex_ctrl(input logic [ID_EX_CTRL_W-1:0] v);
        return id_ex_ctrl_t'(v);
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter for performance debug; q updates 1 cycle after inc.
// No backpressure: holds at all-ones instead of wrapping.
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != CNT_MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register with 2-entry skid; 1-cycle in->out latency, 1 transfer/cycle.
// Backpressure: in_ready is registered and drops only once the skid entry is occupied.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W         = ID_EX_CTRL_W,
    parameter int DATA_W         = ID_EX_DATA_W,
    parameter bit ZERO_ON_BUBBLE = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_t              state;
    logic [CTRL_W-1:0]   skid_ctrl;
    logic [DATA_W-1:0]   skid_data;
    logic                in_fire;
    logic                stall_inc;
    logic                flush_inc;

    assign in_fire   = in_valid & in_ready;
    assign stall_inc = out_valid & ~out_ready;
    assign flush_inc = flush & (state != ST_EMPTY);

    // out_ctrl/out_data are the main entry registers themselves, so the bubble
    // value is written on every transition into EMPTY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_data  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            if (ZERO_ON_BUBBLE) begin
                out_data <= '0;
            end
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                        out_ctrl  <= in_ctrl;
                        out_data  <= in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_ready) begin
                        out_ctrl <= in_ctrl;
                        out_data <= in_data;
                    end else if (in_fire) begin
                        state     <= ST_FULL;
                        in_ready  <= 1'b0;
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end else if (out_ready) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                        out_ctrl  <= '0;
                        if (ZERO_ON_BUBBLE) begin
                            out_data <= '0;
                        end
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the downstream side can move.
                    if (out_ready) begin
                        state     <= ST_ONE;
                        in_ready  <= 1'b1;
                        out_ctrl  <= skid_ctrl;
                        out_data  <= skid_data;
                        skid_ctrl <= '0;
                        skid_data <= '0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_ctrl  <= '0;
                    out_data  <= '0;
                    skid_ctrl <= '0;
                    skid_data <= '0;
                end
            endcase
        end
    end

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (stall_inc),
        .q     (stall_cnt)
    );

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (flush_inc),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench: two configurations driven by one stimulus, checked against a queue model every cycle.
module tb_pipe_stage_buf;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [7:0]   in_ctrl;
    logic [274:0] in_data;
    logic [15:0]  in_data1;

    logic         in_ready0, out_valid0, in_ready1, out_valid1;
    logic [7:0]   out_ctrl0, out_ctrl1;
    logic [274:0] out_data0;
    logic [15:0]  out_data1;
    logic [15:0]  stall_cnt0, flush_cnt0;
    logic [3:0]   stall_cnt1, flush_cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    assign in_data1 = in_data[15:0];

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .CTRL_W(8), .DATA_W(275), .ZERO_ON_BUBBLE(1'b1), .CNT_W(16)
    ) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    pipe_stage_buf #(
        .CTRL_W(8), .DATA_W(16), .ZERO_ON_BUBBLE(1'b0), .CNT_W(4)
    ) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1),
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    task automatic chk(input string nm, input logic [274:0] act, input logic [274:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [274:0] mkdata(input logic [7:0] c);
        logic [274:0] d;
        d = '0;
        for (int i = 0; i < 34; i++) d[i*8 +: 8] = c + 8'(i);
        d[274:272] = c[2:0];
        return d;
    endfunction

    // Model: the stage is a FIFO of at most two entries.
    typedef struct {
        logic [7:0]   c;
        logic [274:0] d;
    } ent_t;

    ent_t         mq[$];
    int           m_stall = 0;
    int           m_flush = 0;
    logic [274:0] m_last = '0;
    bit           seen_rst = 0;
    bit           m_nonempty, m_infire, m_outfire;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_stall  = 0;
            m_flush  = 0;
            m_last   = '0;
            seen_rst = 1;
        end else if (seen_rst) begin
            m_nonempty = (mq.size() != 0);
            m_infire   = in_valid && (mq.size() < 2);
            m_outfire  = m_nonempty && out_ready;
            if (m_nonempty && !out_ready) m_stall++;
            if (flush) begin
                if (m_nonempty) m_flush++;
                mq.delete();
            end else begin
                if (m_outfire) void'(mq.pop_front());
                if (m_infire) mq.push_back('{c: in_ctrl, d: in_data});
            end
            if (mq.size() != 0) m_last = mq[0].d;
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    logic         e_valid, e_ready;
    logic [7:0]   e_ctrl;
    logic [274:0] e_data0, e_data1;

    always @(negedge clk) begin
        if (seen_rst) begin
            e_valid = (mq.size() != 0);
            e_ready = (mq.size() < 2);
            e_ctrl  = e_valid ? mq[0].c : 8'h00;
            e_data0 = e_valid ? mq[0].d : '0;
            e_data1 = e_valid ? mq[0].d : m_last;
            chk("out_valid0", out_valid0, e_valid);
            chk("in_ready0",  in_ready0,  e_ready);
            chk("out_ctrl0",  out_ctrl0,  e_ctrl);
            chk("out_data0",  out_data0,  e_data0);
            chk("stall_cnt0", stall_cnt0, sat(m_stall, 65535));
            chk("flush_cnt0", flush_cnt0, sat(m_flush, 65535));
            chk("out_valid1", out_valid1, e_valid);
            chk("in_ready1",  in_ready1,  e_ready);
            chk("out_ctrl1",  out_ctrl1,  e_ctrl);
            chk("out_data1",  out_data1,  e_data1[15:0]);
            chk("stall_cnt1", stall_cnt1, sat(m_stall, 15));
            chk("flush_cnt1", flush_cnt1, sat(m_flush, 15));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = mkdata(c);
    endtask

    task automatic idle;
        in_valid = 1'b0;
        in_ctrl  = 'x;
        in_data  = 'x;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        tick; tick;
        chk("rst_in_ready", in_ready0, 1'b1);
        chk("rst_out_valid", out_valid0, 1'b0);
        reset = 1'b0;
        idle;
        tick;

        // Stream: each ctrl appears one cycle after it is offered
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            send(8'(k));
            tick;
            chk("stream_ctrl", out_ctrl0, 8'(k));
            chk("stream_rdy", in_ready0, 1'b1);
        end
        idle;
        tick;
        chk("stream_drain_valid", out_valid0, 1'b0);
        chk("stream_stall", stall_cnt0, 16'd0);
        chk("stream_hold_data1", out_data1, 16'h0B0A);

        // Backpressure: A, B fill the stage, C waits upstream
        out_ready = 1'b0;
        send(8'h11); tick;
        send(8'h12); tick;
        chk("bp_full_rdy", in_ready0, 1'b0);
        send(8'h13);
        repeat (3) tick;
        chk("bp_hold_ctrl", out_ctrl0, 8'h11);
        chk("bp_stall", stall_cnt0, 16'd4);
        out_ready = 1'b1;
        tick;
        chk("bp_out_b", out_ctrl0, 8'h12);
        tick;
        chk("bp_out_c", out_ctrl0, 8'h13);
        idle;
        tick;
        chk("bp_empty", out_valid0, 1'b0);
        chk("bp_stall_final", stall_cnt0, 16'd4);

        // Flush in FULL with C offered the same cycle
        out_ready = 1'b0;
        send(8'h21); tick;
        send(8'h22); tick;
        send(8'h23); flush = 1'b1;
        tick;
        flush = 1'b0; idle;
        chk("fl_valid", out_valid0, 1'b0);
        chk("fl_ctrl", out_ctrl0, 8'h00);
        chk("fl_rdy", in_ready0, 1'b1);
        chk("fl_cnt", flush_cnt0, 16'd1);
        chk("fl_zero_data0", out_data0, 275'd0);
        chk("fl_hold_data1", out_data1, 16'h2221);
        tick;
        chk("fl_c_lost", out_valid0, 1'b0);

        // Flush on EMPTY is not counted
        flush = 1'b1; tick;
        flush = 1'b0;
        chk("fl_empty_cnt0", flush_cnt0, 16'd1);
        chk("fl_empty_cnt1", flush_cnt1, 4'd1);

        // Saturation of the 4-bit counter
        send(8'h31); tick;
        idle;
        repeat (9) tick;
        chk("sat_reach", stall_cnt1, 4'd15);
        repeat (11) tick;
        chk("sat_hold", stall_cnt1, 4'd15);
        chk("sat_wide", stall_cnt0, 16'd26);

        // Reset together with flush while FULL
        send(8'h32); tick;
        chk("pre_rst_rdy", in_ready0, 1'b0);
        idle;
        reset = 1'b1; flush = 1'b1;
        tick;
        reset = 1'b0; flush = 1'b0;
        chk("rf_valid", out_valid0, 1'b0);
        chk("rf_rdy", in_ready0, 1'b1);
        chk("rf_ctrl", out_ctrl0, 8'h00);
        chk("rf_data1", out_data1, 16'h0000);
        chk("rf_stall0", stall_cnt0, 16'd0);
        chk("rf_flush0", flush_cnt0, 16'd0);
        chk("rf_stall1", stall_cnt1, 4'd0);
        tick; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
